// File: rtl/sms4_pkg.sv
// Shared SMS4 constants: FK words, S-box table, key-schedule FSM states and widths.
// Consumed by the key expander and the round-function datapath.
package sms4_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned NUM_RK = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    localparam word_t FK0 = 32'hA3B1BAC6;
    localparam word_t FK1 = 32'h56AA3350;
    localparam word_t FK2 = 32'h677D9197;
    localparam word_t FK3 = 32'hB27022DC;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
    function automatic word_t l_prime(input word_t b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sms4_key_expand_if.sv
// Key-load / round-key streaming bus of the SMS4 key expander.
// SMS4_KEY_STORE_EN adds the round-key file read port and keys_ready.
interface sms4_key_expand_if;
    import sms4_pkg::*;

    logic                 start;
    logic [KEY_W-1:0]     mk;
    idx_t                 counter;
    word_t                ck;
    word_t                rk;
    logic                 rk_valid;
    idx_t                 rk_idx;
    logic                 busy;
    logic                 done;
`ifdef SMS4_KEY_STORE_EN
    idx_t                 rd_idx;
    word_t                rd_rk;
    logic                 keys_ready;

    modport master (
        output start, mk, ck, rd_idx,
        input  counter, rk, rk_valid, rk_idx, busy, done, rd_rk, keys_ready
    );
    modport slave (
        input  start, mk, ck, rd_idx,
        output counter, rk, rk_valid, rk_idx, busy, done, rd_rk, keys_ready
    );
`else
    modport master (
        output start, mk, ck,
        input  counter, rk, rk_valid, rk_idx, busy, done
    );
    modport slave (
        input  start, mk, ck,
        output counter, rk, rk_valid, rk_idx, busy, done
    );
`endif

endinterface

// File: rtl/sms4_tau.sv
// SMS4 non-linear tau: four parallel S-box byte substitutions, purely combinational.
module sms4_tau
    import sms4_pkg::*;
(
    input  word_t a_i,
    output word_t tau_c_o
);

    always_comb begin
        tau_c_o = '0;
        for (int j = 0; j < 4; j++) begin
            tau_c_o[8*j +: 8] = SBOX[a_i[8*j +: 8]];
        end
    end

endmodule

// File: rtl/sms4_key_expand.sv
// SMS4 key schedule: expands a 128-bit master key into rk0..rk31, one round key per clock.
// Optional round-key file with read port under SMS4_KEY_STORE_EN.
module sms4_key_expand
    import sms4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    sms4_key_expand_if.slave   bus
);

    ks_state_e    state_q, state_d;
    idx_t         cnt_q, cnt_d;
    word_t [3:0]  k_q, k_d;
    word_t        rk_q, rk_d;
    logic         rk_valid_q, rk_valid_d;
    idx_t         rk_idx_q, rk_idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         start_acc_c;

    word_t        t_c;
    word_t        b_c;
    word_t        new_c;

    // Round-key datapath: new = K0 ^ L'(tau(K1^K2^K3^CK)).
    assign t_c   = k_q[1] ^ k_q[2] ^ k_q[3] ^ bus.ck;
    assign new_c = k_q[0] ^ l_prime(b_c);

    sms4_tau u_tau (
        .a_i     (t_c),
        .tau_c_o (b_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        rk_d        = rk_q;
        rk_valid_d  = 1'b0;
        rk_idx_d    = rk_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_acc_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc_c = 1'b1;
                    k_d[0]      = bus.mk[127:96] ^ FK0;
                    k_d[1]      = bus.mk[95:64]  ^ FK1;
                    k_d[2]      = bus.mk[63:32]  ^ FK2;
                    k_d[3]      = bus.mk[31:0]   ^ FK3;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                rk_d       = new_c;
                rk_idx_d   = cnt_q;
                rk_valid_d = 1'b1;
                k_d[0]     = k_q[1];
                k_d[1]     = k_q[2];
                k_d[2]     = k_q[3];
                k_d[3]     = new_c;
                cnt_d      = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(NUM_RK - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.counter  = cnt_q;
    assign bus.rk       = rk_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef SMS4_KEY_STORE_EN
    word_t key_mem [NUM_RK];
    logic  keys_ready_q;

    // Written on the same edge as rk, so the file is current once keys_ready rises.
    always_ff @(posedge clk) begin
        if (rk_valid_d) begin
            key_mem[rk_idx_d] <= rk_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_ready_q <= 1'b0;
        end else if (start_acc_c) begin
            keys_ready_q <= 1'b0;
        end else if (done_d) begin
            keys_ready_q <= 1'b1;
        end
    end

    assign bus.rd_rk      = key_mem[bus.rd_idx];
    assign bus.keys_ready = keys_ready_q;
`endif

endmodule

// File: tb/tb_sms4_key_expand.sv
// Directed bench for sms4_key_expand: standard test key, restart/reset/back-to-back cases.
// Key-store read-back checks compile in when SMS4_KEY_STORE_EN is defined.
module tb_sms4_key_expand;

    typedef logic [31:0] rk_arr_t [32];

    localparam logic [127:0] MK_STD  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] MK_ZERO = 128'h0;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rk_arr_t exp_std;
    rk_arr_t exp_zero;

    sms4_key_expand_if bus ();

    sms4_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CK byte j of word i is (4i+j)*7 mod 256, byte 0 in the MSBs.
    function automatic logic [31:0] ck_of(input logic [4:0] i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) begin
            c[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
        end
        return c;
    endfunction

    always_comb bus.ck = ck_of(bus.counter);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference key schedule over the full K[0..35] sequence.
    function automatic rk_arr_t sms4_model(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] t;
        logic [31:0] b;
        rk_arr_t     r;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_of(5'(i));
            for (int j = 0; j < 4; j++) begin
                b[8*j +: 8] = sms4_pkg::SBOX[t[8*j +: 8]];
            end
            k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            r[i]   = k[i+4];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; pulses start across the next rising edge.
    task automatic start_run(input logic [127:0] key);
        bus.start = 1'b1;
        bus.mk    = key;
        @(negedge clk);
        bus.start = 1'b0;
        check("run0_counter", 32'(bus.counter), 32'd0);
        check("run0_busy", 32'(bus.busy), 32'd1);
        check("run0_valid", 32'(bus.rk_valid), 32'd0);
        check("ck_first", bus.ck, 32'h00070E15);
    endtask

    // Follows a run cycle by cycle; returns at the done negedge or right after a reset.
    task automatic stream(input rk_arr_t exp, input bit hard, input int repulse_at, input int reset_at);
        for (int i = 0; i < 32; i++) begin
            check("counter", 32'(bus.counter), 32'(i));
            if (i == 31) check("ck_last", bus.ck, 32'h646B7279);
            @(negedge clk);
            bus.start = 1'b0;
            check("rk_valid", 32'(bus.rk_valid), 32'd1);
            check("rk_idx", 32'(bus.rk_idx), 32'(i));
            check("rk", bus.rk, exp[i]);
            check("done", 32'(bus.done), 32'(i == 31));
            check("busy", 32'(bus.busy), 32'(i != 31));
            if (hard && i == 0)  check("rk0_std", bus.rk, 32'hF12186F9);
            if (hard && i == 1)  check("rk1_std", bus.rk, 32'h41662B61);
            if (hard && i == 31) check("rk31_std", bus.rk, 32'h9124A012);
            if (i == repulse_at) begin
                bus.start = 1'b1;
                bus.mk    = ~bus.mk;
            end
            if (i == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_rk", bus.rk, 32'd0);
                check("rst_valid", 32'(bus.rk_valid), 32'd0);
                check("rst_idx", 32'(bus.rk_idx), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_done", 32'(bus.done), 32'd0);
                check("rst_counter", 32'(bus.counter), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mk    = '0;
`ifdef SMS4_KEY_STORE_EN
        bus.rd_idx = '0;
`endif
        exp_std  = sms4_model(MK_STD);
        exp_zero = sms4_model(MK_ZERO);

        repeat (2) @(negedge clk);
        check("reset_rk", bus.rk, 32'd0);
        check("reset_valid", 32'(bus.rk_valid), 32'd0);
        check("reset_idx", 32'(bus.rk_idx), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_counter", 32'(bus.counter), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Standard key, plain run.
        start_run(MK_STD);
        stream(exp_std, 1'b1, -1, -1);
        @(negedge clk);
        check("idle_valid", 32'(bus.rk_valid), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_counter", 32'(bus.counter), 32'd0);
        check("idle_rk_hold", bus.rk, 32'h9124A012);
`ifdef SMS4_KEY_STORE_EN
        check("keys_ready_set", 32'(bus.keys_ready), 32'd1);
        bus.rd_idx = 5'd0;
        #1 check("rd_rk0", bus.rd_rk, 32'hF12186F9);
        bus.rd_idx = 5'd31;
        #1 check("rd_rk31", bus.rd_rk, 32'h9124A012);
        bus.rd_idx = 5'd1;
        #1 check("rd_rk1", bus.rd_rk, 32'h41662B61);
`endif

        // start re-pulsed mid-run must be ignored.
        @(negedge clk);
        start_run(MK_STD);
`ifdef SMS4_KEY_STORE_EN
        check("keys_ready_clr", 32'(bus.keys_ready), 32'd0);
`endif
        stream(exp_std, 1'b1, 10, -1);
        @(negedge clk);
        check("repulse_idle_valid", 32'(bus.rk_valid), 32'd0);
        check("repulse_idle_busy", 32'(bus.busy), 32'd0);

        // Reset mid-run abandons the expansion.
        @(negedge clk);
        start_run(MK_STD);
        stream(exp_std, 1'b1, -1, 15);
        for (int c = 0; c < 3; c++) begin
            check("post_rst_done", 32'(bus.done), 32'd0);
            check("post_rst_valid", 32'(bus.rk_valid), 32'd0);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end
`ifdef SMS4_KEY_STORE_EN
        check("keys_ready_rst", 32'(bus.keys_ready), 32'd0);
`endif

        // Fresh run after reset, then back-to-back all-zero key in the cycle after done.
        start_run(MK_STD);
        stream(exp_std, 1'b1, -1, -1);
        start_run(MK_ZERO);
        stream(exp_zero, 1'b0, -1, -1);
        @(negedge clk);
        check("b2b_idle_valid", 32'(bus.rk_valid), 32'd0);
        check("b2b_rk_hold", bus.rk, exp_zero[31]);
`ifdef SMS4_KEY_STORE_EN
        check("keys_ready_b2b", 32'(bus.keys_ready), 32'd1);
        bus.rd_idx = 5'd0;
        #1 check("rd_zero_rk0", bus.rd_rk, exp_zero[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
